pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, sets the register-index width.
REQ-002 Parameter CNT_W, default 16, sets the stall-counter width.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 Port id_valid, input, 1 bit, means the ID stage holds a real instruction.
REQ-006 Ports id_rs and id_rt, input, REG_AW bits each, are the ID source register indices.
REQ-007 Ports id_use_rs and id_use_rt, input, 1 bit each, mark that the ID instruction reads rs or rt.
REQ-008 Port id_wr_en, input, 1 bit, means the ID instruction writes a register.
REQ-009 Port id_wr_reg, input, REG_AW bits, is the ID destination index (already rt/rd-selected).
REQ-010 Port id_is_load, input, 1 bit, marks the ID instruction as a memory load.
REQ-011 Port id_jump, input, 1 bit, means a jump is decoded in ID.
REQ-012 Port me_br_taken, input, 1 bit, means a branch resolved taken in ME.
REQ-013 Port stall, output, 1 bit, holds the PC and IF/ID registers.
REQ-014 Port flush_id, output, 1 bit, clears IF/ID.
REQ-015 Port flush_ex, output, 1 bit, loads a bubble into ID/EX.
REQ-016 Ports ex_fwd_a and ex_fwd_b, output, 2 bits each, are the EX operand-select codes: 0 regfile, 1 ME ALU result, 2 WB write data.
REQ-017 Port stall_cnt, output, CNT_W bits, counts stall cycles and saturates.

Function
REQ-018 The block SHALL keep a 3-entry scoreboard; each entry holds {v, wr, reg, ld}; entry 0 is EX, entry 1 is ME, entry 2 is WB.
REQ-019 On each edge the scoreboard SHALL shift: entry 2 takes entry 1, entry 1 takes entry 0, and entry 0 takes the ID instruction, or a bubble (v=0) when flush_ex=1.
REQ-020 A match SHALL mean: entry v=1 and wr=1 and reg == source and source != 0 and the corresponding id_use bit =1.
REQ-021 Entry 2 matches SHALL be ignored, because the register file is write-before-read.
REQ-022 stall SHALL equal id_valid AND hazard AND NOT me_br_taken; the hazard definition is in Configuration.
REQ-023 flush_ex SHALL equal stall OR me_br_taken.
REQ-024 flush_id SHALL equal me_br_taken OR (id_jump AND id_valid AND NOT stall).
REQ-025 When me_br_taken=1, entry 0 SHALL be written into entry 1 with v=0, which kills the EX-stage instruction.
REQ-026 stall, flush_id and flush_ex SHALL be combinational with zero-cycle latency.
REQ-027 ex_fwd_a and ex_fwd_b SHALL be registered: they are computed from the ID sources against entries 0 and 1, then registered so they are valid while the consumer is in EX.
REQ-028 The fwd code from an entry-0 match SHALL be 1, and from an entry-1 match SHALL be 2; entry 0 has priority.
REQ-029 The fwd codes SHALL be registered as 0 when flush_ex=1.
REQ-030 stall_cnt SHALL increment by 1 per cycle with stall=1 and hold at all-ones.

Reset
REQ-031 rst=0 SHALL asynchronously clear all scoreboard v bits, ex_fwd_a, ex_fwd_b and stall_cnt to 0.
REQ-032 During reset, stall, flush_id and flush_ex SHALL read 0.
REQ-033 Reset asserted mid-stall SHALL discard the pending hazard; the first cycle after release SHALL see an empty scoreboard.

Configuration
REQ-034 With macro PIPE_HAZARD_FWD_EN defined, the hazard SHALL be an entry-0 match with ld=1 only (load-use, one stall cycle), and forwarding SHALL be active.
REQ-035 Without PIPE_HAZARD_FWD_EN, the hazard SHALL be any entry-0 or entry-1 match (up to two stall cycles), and ex_fwd_a and ex_fwd_b SHALL be constant 0.

Verification
REQ-036 The bench SHALL cover, with FWD_EN: add $3 in entry 0, then ID reads rs=$3 -> no stall, and ex_fwd_a=1 the next cycle.
REQ-037 The bench SHALL cover, with FWD_EN: lw $4 in entry 0, then ID reads rt=$4 -> stall=1 for exactly 1 cycle, flush_ex=1, and after that ex_fwd_b=2 with stall_cnt=1.
REQ-038 The bench SHALL cover, without FWD_EN: add $5 in entry 0, then ID reads $5 -> stall for 2 cycles, then ex_fwd_a=0 and stall_cnt=2.
REQ-039 The bench SHALL cover: an ID write to $0 followed by a read of $0 -> never stalls, and fwd stays 0.
REQ-040 The bench SHALL cover: me_br_taken=1 in the same cycle as a load-use hazard -> stall=0, flush_id=1, flush_ex=1, and entry 1 has v=0 next cycle.
REQ-041 The bench SHALL cover: stall held for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones; then rst=0 -> stall_cnt=0 immediately, with no clock edge.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/flush/forward control from a 3-entry EX/ME/WB writer scoreboard
// Optional build macro PIPE_HAZARD_FWD_EN: forwarding on, only load-use hazards stall.
module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              id_jump,
    input  logic              me_br_taken,
    output logic              stall,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic              v;
        logic              wr;
        logic [REG_AW-1:0] rg;
        logic              ld;
    } sb_entry_t;

    // sb[0] = EX, sb[1] = ME, sb[2] = WB
    sb_entry_t sb [3];
    sb_entry_t id_entry;
    sb_entry_t ex_next_me;
    logic      m0_rs, m0_rt, m1_rs, m1_rt;
    logic      hazard, stall_raw, flush_ex_raw;

    // WB writers are never consulted: the register file writes before it is read.
    always_comb begin
        m0_rs = sb[0].v && sb[0].wr && (sb[0].rg == id_rs) && (id_rs != '0) && id_use_rs;
        m0_rt = sb[0].v && sb[0].wr && (sb[0].rg == id_rt) && (id_rt != '0) && id_use_rt;
        m1_rs = sb[1].v && sb[1].wr && (sb[1].rg == id_rs) && (id_rs != '0) && id_use_rs;
        m1_rt = sb[1].v && sb[1].wr && (sb[1].rg == id_rt) && (id_rt != '0) && id_use_rt;
    end

`ifdef PIPE_HAZARD_FWD_EN
    assign hazard = sb[0].ld && (m0_rs || m0_rt);
`else
    assign hazard = m0_rs || m0_rt || m1_rs || m1_rt;
`endif

    assign stall_raw    = id_valid && hazard && !me_br_taken;
    assign flush_ex_raw = stall_raw || me_br_taken;

    // Outputs are forced low while reset is held, even if me_br_taken is high.
    assign stall    = rst && stall_raw;
    assign flush_ex = rst && flush_ex_raw;
    assign flush_id = rst && (me_br_taken || (id_jump && id_valid && !stall_raw));

    always_comb begin
        id_entry = '{v: id_valid, wr: id_wr_en, rg: id_wr_reg, ld: id_is_load};
        if (flush_ex_raw) begin
            id_entry = '0;
        end
        ex_next_me = sb[0];
        if (me_br_taken) begin
            ex_next_me.v = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[2] <= sb[1];
            sb[1] <= ex_next_me;
            sb[0] <= id_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_raw && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // EX-stage producer is the youngest, so it wins over ME.
    always_comb begin
        fwd_a_nxt = 2'd0;
        fwd_b_nxt = 2'd0;
        if (m0_rs) begin
            fwd_a_nxt = 2'd1;
        end else if (m1_rs) begin
            fwd_a_nxt = 2'd2;
        end
        if (m0_rt) begin
            fwd_b_nxt = 2'd1;
        end else if (m1_rt) begin
            fwd_b_nxt = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_fwd_a <= 2'd0;
            ex_fwd_b <= 2'd0;
        end else begin
            ex_fwd_a <= flush_ex_raw ? 2'd0 : fwd_a_nxt;
            ex_fwd_b <= flush_ex_raw ? 2'd0 : fwd_b_nxt;
        end
    end
`else
    assign ex_fwd_a = 2'd0;
    assign ex_fwd_b = 2'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit against a pipeline-occupancy model
module tb_pipe_hazard_unit;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_jump, me_br_taken;
    logic [REG_AW-1:0] id_rs, id_rt, id_wr_reg;
    logic              stall, flush_id, flush_ex;
    logic [1:0]        ex_fwd_a, ex_fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_jump(id_jump),
        .me_br_taken(me_br_taken), .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit valid; int rs; bit use_rs; int rt; bit use_rt; bit wr; int wr_reg; bit ld; bit jump; } instr_t;
    typedef struct { bit v; bit wr; int rd; bit ld; } prod_t;
    typedef struct { bit stall; bit flush_id; bit flush_ex; int fwd_a; int fwd_b; int cnt; } exp_t;

    int    checks   = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    prod_t inflight[$];   // [0] = instruction now in EX, [1] = now in ME
    int    m_fwd_a, m_fwd_b, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic instr_t mk(bit valid, int rs, bit urs, int rt, bit urt, bit wr, int wreg, bit ld, bit jump);
        instr_t r;
        r = '{valid, rs, urs, rt, urt, wr, wreg, ld, jump};
        return r;
    endfunction

    function automatic void model_clear();
        inflight.delete();
        inflight.push_back('{0, 0, 0, 0});
        inflight.push_back('{0, 0, 0, 0});
        m_fwd_a = 0;
        m_fwd_b = 0;
        m_cnt   = 0;
    endfunction

    // Distance to the youngest in-flight writer of src: 1 = EX, 2 = ME, 0 = none.
    function automatic int producer_dist(int src, bit used);
        if (!used || src == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (inflight[i].v && inflight[i].wr && inflight[i].rd == src) return i + 1;
        return 0;
    endfunction

    task automatic drive(input instr_t ins, input bit br);
        id_valid    = ins.valid;
        id_rs       = REG_AW'(ins.rs);
        id_use_rs   = ins.use_rs;
        id_rt       = REG_AW'(ins.rt);
        id_use_rt   = ins.use_rt;
        id_wr_en    = ins.wr;
        id_wr_reg   = REG_AW'(ins.wr_reg);
        id_is_load  = ins.ld;
        id_jump     = ins.jump;
        me_br_taken = br;
    endtask

    task automatic step(input instr_t ins, input bit br, output exp_t e);
        int    da, db;
        bit    hz;
        prod_t nw;
        @(posedge clk);
        #1;
        drive(ins, br);
        da = producer_dist(ins.rs, ins.use_rs);
        db = producer_dist(ins.rt, ins.use_rt);
        if (FWD) hz = (da == 1 || db == 1) && inflight[0].ld;
        else     hz = (da != 0 || db != 0);
        e.stall    = ins.valid && hz && !br;
        e.flush_ex = e.stall || br;
        e.flush_id = br || (ins.jump && ins.valid && !e.stall);
        e.fwd_a    = m_fwd_a;
        e.fwd_b    = m_fwd_b;
        e.cnt      = m_cnt;
        exp_q.push_back(e);
        m_fwd_a = (!FWD || e.flush_ex) ? 0 : da;
        m_fwd_b = (!FWD || e.flush_ex) ? 0 : db;
        if (e.stall && m_cnt < CNT_MAX) m_cnt++;
        if (br) inflight[0].v = 1'b0;
        if (e.flush_ex) nw = '{0, 0, 0, 0};
        else            nw = '{ins.valid, ins.wr, ins.wr_reg, ins.ld};
        inflight.push_front(nw);
        void'(inflight.pop_back());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_stall", stall, e.stall);
                check("sb_flush_id", flush_id, e.flush_id);
                check("sb_flush_ex", flush_ex, e.flush_ex);
                check("sb_fwd_a", ex_fwd_a, e.fwd_a);
                check("sb_fwd_b", ex_fwd_b, e.fwd_b);
                check("sb_cnt", stall_cnt, e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        exp_t   e;
        instr_t nop, cur, lr;
        bit     hold;
        int     nst;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lr  = mk(1, 5, 1, 0, 0, 1, 5, 1, 0);
        model_clear();

        rst = 1'b0;
        drive(mk(1, 3, 1, 3, 1, 1, 3, 1, 1), 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_flush_id", flush_id, 0);
        check("rst_flush_ex", flush_ex, 0);
        check("rst_fwd_a", ex_fwd_a, 0);
        check("rst_fwd_b", ex_fwd_b, 0);
        check("rst_cnt", stall_cnt, 0);
        drive(nop, 1'b0);
        rst = 1'b1;

`ifdef PIPE_HAZARD_FWD_EN
        step(mk(1, 0, 0, 0, 0, 1, 4, 1, 0), 1'b0, e);
        step(mk(1, 0, 0, 4, 1, 1, 7, 0, 0), 1'b0, e);
        @(negedge clk);
        check("lu_stall", stall, 1);
        check("lu_flush_ex", flush_ex, 1);
        step(mk(1, 0, 0, 4, 1, 1, 7, 0, 0), 1'b0, e);
        @(negedge clk);
        check("lu_stall_once", stall, 0);
        step(nop, 1'b0, e);
        @(negedge clk);
        check("lu_fwd_b", ex_fwd_b, 2);
        check("lu_cnt", stall_cnt, 1);

        step(mk(1, 1, 1, 2, 1, 1, 3, 0, 0), 1'b0, e);
        step(mk(1, 3, 1, 0, 0, 1, 8, 0, 0), 1'b0, e);
        @(negedge clk);
        check("alu_no_stall", stall, 0);
        step(nop, 1'b0, e);
        @(negedge clk);
        check("alu_fwd_a", ex_fwd_a, 1);
`else
        step(mk(1, 1, 1, 2, 1, 1, 5, 0, 0), 1'b0, e);
        step(mk(1, 5, 1, 0, 0, 1, 8, 0, 0), 1'b0, e);
        @(negedge clk);
        check("nf_stall1", stall, 1);
        step(mk(1, 5, 1, 0, 0, 1, 8, 0, 0), 1'b0, e);
        @(negedge clk);
        check("nf_stall2", stall, 1);
        step(mk(1, 5, 1, 0, 0, 1, 8, 0, 0), 1'b0, e);
        @(negedge clk);
        check("nf_stall_end", stall, 0);
        step(nop, 1'b0, e);
        @(negedge clk);
        check("nf_fwd_a", ex_fwd_a, 0);
        check("nf_cnt", stall_cnt, 2);
`endif

        step(mk(1, 0, 0, 0, 0, 1, 0, 1, 0), 1'b0, e);
        step(mk(1, 0, 1, 0, 1, 1, 9, 0, 0), 1'b0, e);
        @(negedge clk);
        check("r0_stall", stall, 0);
        check("r0_flush_ex", flush_ex, 0);
        step(nop, 1'b0, e);
        @(negedge clk);
        check("r0_fwd_a", ex_fwd_a, 0);
        check("r0_fwd_b", ex_fwd_b, 0);

        step(mk(1, 0, 0, 0, 0, 1, 6, 1, 0), 1'b0, e);
        step(mk(1, 6, 1, 0, 0, 1, 9, 0, 0), 1'b1, e);
        @(negedge clk);
        check("br_stall", stall, 0);
        check("br_flush_id", flush_id, 1);
        check("br_flush_ex", flush_ex, 1);
        step(mk(1, 6, 1, 0, 0, 1, 9, 0, 0), 1'b0, e);
        @(negedge clk);
        check("br_killed_stall", stall, 0);
        step(nop, 1'b0, e);
        @(negedge clk);
        check("br_killed_fwd", ex_fwd_a, 0);

        hold = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!hold)
                cur = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                         $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            step(cur, $urandom_range(0, 9) == 0, e);
            hold = e.stall;
        end

        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        drive(nop, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        nst = 0;
        for (int i = 0; i < 2000 && nst < CNT_MAX + 4; i++) begin
            step(lr, 1'b0, e);
            if (e.stall) nst++;
        end
        @(negedge clk);
        check("sat_in_stall", stall, 1);
        check("sat_cnt", stall_cnt, CNT_MAX);
        #2;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("arst_cnt", stall_cnt, 0);
        check("arst_stall", stall, 0);
        check("arst_flush_ex", flush_ex, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_empty", stall, 0);
        drive(nop, 1'b0);
        step(mk(1, 0, 0, 0, 0, 1, 5, 1, 0), 1'b0, e);
        step(lr, 1'b0, e);
        @(negedge clk);
        check("post_rst_lu", stall, 1);
        step(nop, 1'b0, e);
        step(nop, 1'b0, e);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
